// File: rtl/stack_arbiter_pkg.sv
// Shared types and encodings for the stack arbiter slice.
package stack_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic OP_PUSH = 1'b1;
    localparam logic OP_POP  = 1'b0;

endpackage

// File: rtl/stack_arbiter_if.sv
// Requester-side bus of the stack arbiter: request level/op/data in, grant/response out.
interface stack_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8
);
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ-1:0]            req_op;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
    logic [NUM_REQ-1:0]            gnt;
    logic [NUM_REQ-1:0]            done;
    logic [DATA_WIDTH-1:0]         rsp_data;
    logic                          rsp_err;

    modport master (
        output req, req_op, req_wdata,
        input  gnt, done, rsp_data, rsp_err
    );

    modport slave (
        input  req, req_op, req_wdata,
        output gnt, done, rsp_data, rsp_err
    );
endinterface

// File: rtl/stack_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request bit searching upward from rr_last+1.
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] rr_last,
    output logic [$clog2(N)-1:0] idx,
    output logic                 valid
);
    localparam int IW = $clog2(N);

    logic [IW-1:0] cand;

    // Walk offsets from N down to 1 so the smallest offset with a request wins last.
    always_comb begin
        idx   = rr_last;
        cand  = '0;
        valid = |req;
        for (int unsigned k = 0; k < 32'(N); k++) begin
            cand = IW'((32'(rr_last) + 32'(N) - k) % 32'(N));
            if (req[cand]) begin
                idx = cand;
            end
        end
    end
endmodule

// File: rtl/stack_arbiter.sv
// Round-robin arbiter sharing one LIFO between NUM_REQ requesters; rejects push-full / pop-empty.
module stack_arbiter
    import stack_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    stack_arbiter_if.slave        rq,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  err_cnt,
    output logic                  stk_push,
    output logic                  stk_pop,
    output logic [DATA_WIDTH-1:0] stk_wdata,
    input  logic [DATA_WIDTH-1:0] stk_rdata,
    input  logic                  stk_full,
    input  logic                  stk_empty
);
    localparam int IW = $clog2(NUM_REQ);

    state_t                state;
    logic [IW-1:0]         rr_last;
    logic [IW-1:0]         win_q;
    logic [IW-1:0]         pick_idx;
    logic                  pick_vld;
    logic                  op_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  pop_ok_q;
    logic                  push_ok;
    logic                  pop_ok;
    logic [NUM_REQ-1:0]    gnt_q;
    logic [NUM_REQ-1:0]    done_q;
    logic                  rsp_err_q;
    logic [DATA_WIDTH-1:0] wd_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_wd
        assign wd_arr[g] = rq.req_wdata[g*DATA_WIDTH +: DATA_WIDTH];
    end

    rr_pick #(.N(NUM_REQ)) u_pick (
        .req     (rq.req),
        .rr_last (rr_last),
        .idx     (pick_idx),
        .valid   (pick_vld)
    );

    // Full/empty are looked at only while executing, so strobes are decoded from the live flags.
    always_comb begin
        push_ok = (state == ST_EXEC) && (op_q == OP_PUSH) && !stk_full;
        pop_ok  = (state == ST_EXEC) && (op_q == OP_POP)  && !stk_empty;
    end

    assign stk_push    = push_ok;
    assign stk_pop     = pop_ok;
    assign stk_wdata   = push_ok ? wdata_q : '0;
    assign rq.gnt      = gnt_q;
    assign rq.done     = done_q;
    assign rq.rsp_err  = rsp_err_q;
    assign rq.rsp_data = (state == ST_RESP && pop_ok_q) ? stk_rdata : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            rr_last   <= IW'(NUM_REQ - 1);
            win_q     <= '0;
            op_q      <= OP_POP;
            wdata_q   <= '0;
            pop_ok_q  <= 1'b0;
            gnt_q     <= '0;
            done_q    <= '0;
            rsp_err_q <= 1'b0;
            busy      <= 1'b0;
            err_cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_vld) begin
                        win_q   <= pick_idx;
                        op_q    <= rq.req_op[pick_idx];
                        wdata_q <= wd_arr[pick_idx];
                        rr_last <= pick_idx;
                        gnt_q   <= NUM_REQ'(1) << pick_idx;
                        busy    <= 1'b1;
                        state   <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    gnt_q     <= '0;
                    done_q    <= NUM_REQ'(1) << win_q;
                    rsp_err_q <= !(push_ok || pop_ok);
                    pop_ok_q  <= pop_ok;
                    state     <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_err_q && (err_cnt != '1)) begin
                        err_cnt <= err_cnt + CNT_WIDTH'(1);
                    end
                    done_q    <= '0;
                    rsp_err_q <= 1'b0;
                    pop_ok_q  <= 1'b0;
                    busy      <= 1'b0;
                    state     <= ST_IDLE;
                end
                default: begin
                    gnt_q     <= '0;
                    done_q    <= '0;
                    rsp_err_q <= 1'b0;
                    pop_ok_q  <= 1'b0;
                    busy      <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_stack_arbiter.sv
// Bench for stack_arbiter: directed test-plan cases plus random traffic against a transaction-level model.
module tb_stack_arbiter;
    localparam int DW     = 8;
    localparam int NR     = 4;
    localparam int CW     = 3;
    localparam int SDEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    stack_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();

    logic          busy;
    logic [CW-1:0] err_cnt;
    logic          stk_push;
    logic          stk_pop;
    logic [DW-1:0] stk_wdata;
    logic [DW-1:0] stk_rdata = '0;
    logic          stk_full;
    logic          stk_empty;

    stack_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .CNT_WIDTH(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .rq        (bus),
        .busy      (busy),
        .err_cnt   (err_cnt),
        .stk_push  (stk_push),
        .stk_pop   (stk_pop),
        .stk_wdata (stk_wdata),
        .stk_rdata (stk_rdata),
        .stk_full  (stk_full),
        .stk_empty (stk_empty)
    );

    // Behavioural LIFO the arbiter drives; not affected by the arbiter reset.
    logic [DW-1:0] smem [SDEPTH];
    int            scount = 0;
    always @(posedge clk) begin
        if (stk_push && scount < SDEPTH) begin
            smem[scount] <= stk_wdata;
            scount       <= scount + 1;
        end else if (stk_pop && scount > 0) begin
            stk_rdata <= smem[scount-1];
            scount    <= scount - 1;
        end
    end
    assign stk_full  = (scount == SDEPTH);
    assign stk_empty = (scount == 0);

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: each arbitration yields two expected cycle records.
    typedef struct {
        logic [NR-1:0] gnt;
        logic [NR-1:0] done;
        logic          push;
        logic          pop;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
        logic          err;
        logic          busy;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] mstk[$];
    int            rr   = NR - 1;
    int            mcnt = 0;

    always @(negedge clk) begin
        exp_t x, y, e;
        bit   was_idle, op, err;
        int   w;
        if (rst) begin
            chk("rst_gnt",   bus.gnt, 0);
            chk("rst_done",  bus.done, 0);
            chk("rst_busy",  busy, 0);
            chk("rst_push",  stk_push, 0);
            chk("rst_pop",   stk_pop, 0);
            chk("rst_wdata", stk_wdata, 0);
            chk("rst_rdata", bus.rsp_data, 0);
            chk("rst_err",   bus.rsp_err, 0);
            chk("rst_cnt",   err_cnt, 0);
            exp_q.delete();
            rr   = NR - 1;
            mcnt = 0;
        end else begin
            was_idle = (exp_q.size() == 0);
            if (was_idle)
                e = '{gnt: '0, done: '0, push: 1'b0, pop: 1'b0, wdata: '0, rdata: '0,
                      err: 1'b0, busy: 1'b0, cnt: CW'(mcnt)};
            else
                e = exp_q.pop_front();
            chk("m_gnt",  bus.gnt, e.gnt);
            chk("m_done", bus.done, e.done);
            chk("m_busy", busy, e.busy);
            chk("m_push", stk_push, e.push);
            chk("m_pop",  stk_pop, e.pop);
            chk("m_cnt",  err_cnt, e.cnt);
            if (e.push) chk("m_wdata", stk_wdata, e.wdata);
            if (e.done != 0) begin
                chk("m_rsp_err",  bus.rsp_err, e.err);
                chk("m_rsp_data", bus.rsp_data, e.rdata);
            end
            if (e.push) mstk.push_back(e.wdata);
            if (e.pop) void'(mstk.pop_back());
            if (was_idle && bus.req != 0) begin
                w = -1;
                for (int k = 1; k <= NR; k++)
                    if (w < 0 && bus.req[(rr + k) % NR]) w = (rr + k) % NR;
                rr  = w;
                op  = bus.req_op[w];
                err = op ? (mstk.size() == SDEPTH) : (mstk.size() == 0);
                x = '{gnt: NR'(1) << w, done: '0, push: op && !err, pop: !op && !err,
                      wdata: bus.req_wdata[w*DW +: DW], rdata: '0, err: 1'b0, busy: 1'b1, cnt: CW'(mcnt)};
                y = '{gnt: '0, done: NR'(1) << w, push: 1'b0, pop: 1'b0, wdata: '0, rdata: '0,
                      err: err, busy: 1'b1, cnt: CW'(mcnt)};
                if (!op && !err) y.rdata = mstk[$];
                exp_q.push_back(x);
                exp_q.push_back(y);
                if (err && mcnt < (1 << CW) - 1) mcnt++;
            end
        end
    end

    // Called at posedge+1 of an idle cycle; returns at posedge+1 of the following idle cycle.
    task automatic do_op(input int i, input bit op, input logic [DW-1:0] d,
                         input bit exp_err, input logic [DW-1:0] exp_rd);
        bus.req_op[i]            = op;
        bus.req_wdata[i*DW +: DW] = d;
        bus.req[i]               = 1'b1;
        @(posedge clk); #1;
        chk("d_gnt",  bus.gnt, 32'd1 << i);
        chk("d_push", stk_push, op && !exp_err);
        chk("d_pop",  stk_pop, !op && !exp_err);
        if (op && !exp_err) chk("d_wdata", stk_wdata, d);
        bus.req[i] = 1'b0;
        @(posedge clk); #1;
        chk("d_done",  bus.done, 32'd1 << i);
        chk("d_err",   bus.rsp_err, exp_err);
        chk("d_rdata", bus.rsp_data, exp_rd);
        @(posedge clk); #1;
    endtask

    initial begin
        bus.req       = '0;
        bus.req_op    = '0;
        bus.req_wdata = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        do_op(0, 1'b1, 8'hA5, 1'b0, 8'h00);
        do_op(2, 1'b0, 8'h00, 1'b0, 8'hA5);
        do_op(1, 1'b0, 8'h00, 1'b1, 8'h00);
        chk("d_cnt1", err_cnt, 1);

        for (int k = 0; k < 4; k++) do_op(k, 1'b1, DW'(8'h11 * (k + 1)), 1'b0, 8'h00);
        chk("d_full", stk_full, 1);
        do_op(3, 1'b1, 8'h3C, 1'b1, 8'h00);
        chk("d_cnt2", err_cnt, 2);
        do_op(0, 1'b0, 8'h00, 1'b0, 8'h44);
        do_op(3, 1'b0, 8'h00, 1'b0, 8'h33);
        do_op(3, 1'b0, 8'h00, 1'b0, 8'h22);
        do_op(3, 1'b0, 8'h00, 1'b0, 8'h11);

        for (int i = 0; i < NR; i++) begin
            bus.req_op[i]             = 1'b1;
            bus.req_wdata[i*DW +: DW] = DW'(8'h10 + i);
        end
        bus.req = '1;
        for (int k = 0; k < NR; k++) begin
            @(posedge clk); #1;
            chk("s_gnt",   bus.gnt, 32'd1 << k);
            chk("s_wdata", stk_wdata, 8'h10 + k);
            bus.req[k] = 1'b0;
            @(posedge clk); #1;
            chk("s_done", bus.done, 32'd1 << k);
            @(posedge clk); #1;
        end
        for (int k = NR - 1; k >= 0; k--) do_op(0, 1'b0, 8'h00, 1'b0, DW'(8'h10 + k));

        // Reset during EXEC of a push by requester 1
        bus.req_op[1]       = 1'b1;
        bus.req_wdata[15:8] = 8'h77;
        bus.req[1]          = 1'b1;
        @(posedge clk); #1;
        chk("r_gnt", bus.gnt, 4'b0010);
        chk("r_push", stk_push, 1);
        #1 rst = 1'b1;
        #1;
        chk("r_gnt0",  bus.gnt, 0);
        chk("r_push0", stk_push, 0);
        chk("r_busy0", busy, 0);
        chk("r_cnt0",  err_cnt, 0);
        bus.req[1] = 1'b0;
        @(posedge clk); #1;
        chk("r_done0", bus.done, 0);
        rst        = 1'b0;
        bus.req_op = '0;
        bus.req    = 4'b0011;
        @(posedge clk); #1;
        chk("r_first", bus.gnt, 4'b0001);
        chk("r_pop",   stk_pop, 0);
        bus.req[0] = 1'b0;
        @(posedge clk); #1;
        chk("r_done", bus.done, 4'b0001);
        chk("r_err",  bus.rsp_err, 1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("r_second", bus.gnt, 4'b0010);
        bus.req[1] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("r_cnt2", err_cnt, 2);

        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < NR; i++) begin
                if (bus.req[i] && bus.gnt[i]) begin
                    bus.req[i] = 1'b0;
                end else if (!bus.req[i] && $urandom_range(0, 3) == 0) begin
                    bus.req_op[i]             = 1'($urandom_range(0, 1));
                    bus.req_wdata[i*DW +: DW] = DW'($urandom);
                    bus.req[i]                = 1'b1;
                end
            end
            @(posedge clk); #1;
        end
        bus.req = '0;
        repeat (8) @(posedge clk);
        #1;
        chk("end_idle", busy, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
